instr_mem_loadable: RTL and testbench

//  Parametrised, synchronous-read instruction memory for the MIPS fetch stage.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_load_fsm.sv | 86 ++++++++
 rtl/instr_mem_loadable.sv | 100 ++++++++++
 tb/tb_instr_mem_loadable.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
// State encoding, NOP word and PC-to-word translation helpers.

package imem_pkg;

    // Loader state: RUN serves fetches, LOAD accepts streamed words
    typedef enum logic {
        IMEM_RUN  = 1'b0,
        IMEM_LOAD = 1'b1
    } imem_state_e;

    // Byte address to word index shift (4-byte words)
    localparam int WORD_SHIFT = 2;

    // Widest supported instruction word; NOP is all zeros
    localparam int NOP_MAX_W = 256;
    localparam logic [NOP_MAX_W-1:0] IMEM_NOP = '0;

    // A PC is misaligned when any byte-offset bit is set
    function automatic logic imem_misaligned(
        input logic [WORD_SHIFT-1:0] lo
    );
        return |lo;
    endfunction

endpackage

// File: rtl/imem_load_fsm.sv
// Streaming loader control for the instruction memory.
// Tracks RUN/LOAD, the write pointer and the load_done pulse.

module imem_load_fsm
    import imem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic             load_last,
    output logic             load_ready,
    output logic             busy,
    output logic             load_done,
    output logic             o_run,
    output logic             o_wr_en,
    output logic [PTR_W-1:0] o_wr_addr
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    imem_state_e      r_state;
    imem_state_e      w_state_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_beat;
    logic             w_at_end;

    assign w_at_end = (r_ptr == PTR_LAST);

    // State, pointer and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IMEM_RUN;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; the final slot forces an exit so the pointer never wraps
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = 1'b0;
        w_beat      = 1'b0;
        unique case (r_state)
            IMEM_RUN: begin
                if (load_start) begin
                    w_state_nxt = IMEM_LOAD;
                    w_ptr_nxt   = '0;
                end
            end
            IMEM_LOAD: begin
                w_beat = load_valid;
                if (w_beat) begin
                    w_ptr_nxt = r_ptr + PTR_W'(1);
                    if (load_last || w_at_end) begin
                        w_state_nxt = IMEM_RUN;
                        w_ptr_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IMEM_RUN;
            end
        endcase
    end

    assign load_ready = (r_state == IMEM_LOAD);
    assign busy       = (r_state == IMEM_LOAD);
    assign load_done  = r_done;
    assign o_run      = (r_state == IMEM_RUN);
    assign o_wr_en    = w_beat;
    assign o_wr_addr  = r_ptr;

endmodule

// File: rtl/instr_mem_loadable.sv
// Synchronous-read instruction memory.
// Fault detection and streaming loader.

module instr_mem_loadable
  import imem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WIDX_W = ADDR_W - WORD_SHIFT;
  localparam logic [DATA_W-1:0] NOP =
    IMEM_NOP[DATA_W-1:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_fault;

  logic [WIDX_W-1:0] w_widx;
  logic              w_misal;
  logic              w_oob;
  logic              w_bad;
  logic              w_run;
  logic              w_accept;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_addr;
  logic [DATA_W-1:0] w_rdata;

  imem_load_fsm #(
    .DEPTH (DEPTH),
    .PTR_W (IDX_W)
  ) u_load_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .busy       (busy),
    .load_done  (load_done),
    .o_run      (w_run),
    .o_wr_en    (w_wr_en),
    .o_wr_addr  (w_wr_addr)
  );

  assign w_widx   = fetch_addr[ADDR_W-1:WORD_SHIFT];
  assign w_misal  =
    imem_misaligned(fetch_addr[WORD_SHIFT-1:0]);
  assign w_oob    = (64'(w_widx) >= 64'(DEPTH));
  assign w_bad    = w_misal | w_oob;
  assign w_accept = fetch_en & ~stall & w_run;
  assign w_rdata  = r_mem[w_widx[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (!stall) begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_fault <= w_bad;
        r_instr <= w_bad ? NOP : w_rdata;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign fault       = r_fault;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: table vectors plus loader corner cases.
// A DEPTH=4 instance covers pointer overflow and reset abort.

module tb_instr_mem_loadable;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } exp_t;

    typedef struct {
        logic        fe;
        logic        st;
        logic [31:0] a;
        logic [31:0] ei;
        logic        ev;
        logic        ef;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        load_done;
    logic        busy;

    logic        rst4_n = 1'b1;
    logic        fe4 = 1'b0;
    logic [31:0] a4 = '0;
    logic        st4 = 1'b0;
    logic [31:0] i4;
    logic        v4;
    logic        f4;
    logic        ls4 = 1'b0;
    logic        lv4 = 1'b0;
    logic        ll4 = 1'b0;
    logic [31:0] d4 = '0;
    logic        rdy4;
    logic        done4;
    logic        busy4;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    vec_t tbl[$];
    logic [31:0] w0[4];
    logic [31:0] wl[5];
    logic        vl[5];
    logic        ll[5];
    logic        sl[5];

    always #5 clk = ~clk;

    instr_mem_loadable #(
        .DATA_W (32),
        .DEPTH  (256),
        .ADDR_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fault       (fault),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .busy        (busy)
    );

    instr_mem_loadable #(
        .DATA_W (32),
        .DEPTH  (4),
        .ADDR_W (32)
    ) dut4 (
        .clk         (clk),
        .rst_n       (rst4_n),
        .fetch_en    (fe4),
        .fetch_addr  (a4),
        .stall       (st4),
        .instr       (i4),
        .instr_valid (v4),
        .fault       (f4),
        .load_start  (ls4),
        .load_valid  (lv4),
        .load_last   (ll4),
        .load_data   (d4),
        .load_ready  (rdy4),
        .load_done   (done4),
        .busy        (busy4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic fe, input logic st, input logic [31:0] a,
                        input logic ls, input logic lv, input logic lst,
                        input logic [31:0] d, input logic [31:0] ei,
                        input logic ev, input logic ef, input string nm);
        exp_t e;
        @(negedge clk);
        fetch_en   = fe;
        stall      = st;
        fetch_addr = a;
        load_start = ls;
        load_valid = lv;
        load_last  = lst;
        load_data  = d;
        exp_q.push_back('{ei, ev, ef});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({nm, " instr"}, instr, e.instr);
        chk({nm, " valid"}, 32'(instr_valid), 32'(e.valid));
        chk({nm, " fault"}, 32'(fault), 32'(e.fault));
    endtask

    task automatic tick4(input logic fe, input logic [31:0] a,
                         input logic ls, input logic lv,
                         input logic [31:0] d);
        @(negedge clk);
        fe4 = fe;
        a4  = a;
        ls4 = ls;
        lv4 = lv;
        ll4 = 1'b0;
        d4  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " instr"}, instr, 32'h0);
        chk({nm, " valid"}, 32'(instr_valid), 32'h0);
        chk({nm, " fault"}, 32'(fault), 32'h0);
        chk({nm, " ready"}, 32'(load_ready), 32'h0);
        chk({nm, " done"}, 32'(load_done), 32'h0);
        chk({nm, " busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        w0 = '{32'h20010003, 32'h11111111, 32'h00221818, 32'h33333333};

        tbl.push_back('{1, 0, 32'h0,        32'h20010003, 1, 0});
        tbl.push_back('{1, 0, 32'h8,        32'h00221818, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        32'h00221818, 0, 0});
        tbl.push_back('{1, 0, 32'h6,        32'h0,        1, 1});
        tbl.push_back('{1, 0, 32'h400,      32'h0,        1, 1});
        tbl.push_back('{1, 0, 32'h4,        32'h11111111, 1, 0});
        tbl.push_back('{1, 0, 32'h0,        32'h20010003, 1, 0});
        tbl.push_back('{1, 1, 32'h4,        32'h20010003, 1, 0});
        tbl.push_back('{1, 1, 32'h4,        32'h20010003, 1, 0});
        tbl.push_back('{1, 1, 32'h4,        32'h20010003, 1, 0});
        tbl.push_back('{1, 0, 32'h4,        32'h11111111, 1, 0});
        tbl.push_back('{0, 1, 32'h6,        32'h11111111, 1, 0});
        tbl.push_back('{1, 0, 32'hC,        32'h33333333, 1, 0});
        tbl.push_back('{1, 0, 32'h40000000, 32'h0,        1, 1});
        tbl.push_back('{0, 0, 32'h0,        32'h0,        0, 1});
        tbl.push_back('{1, 0, 32'h0,        32'h20010003, 1, 0});
        tbl.push_back('{1, 0, 32'h2,        32'h0,        1, 1});
        tbl.push_back('{1, 1, 32'h0,        32'h0,        1, 1});

        // async reset before any clocked activity
        #2;
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        rst4_n = 1'b1;

        // program the main instance through the loader
        tick(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, "start");
        chk("start busy", 32'(busy), 32'h1);
        chk("start ready", 32'(load_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 1, (i == 3), w0[i], 32'h0, 0, 0, "prog");
            chk("prog done", 32'(load_done), 32'((i == 3)));
        end
        chk("prog busy", 32'(busy), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].fe, tbl[i].st, tbl[i].a, 0, 0, 0, 0,
                 tbl[i].ei, tbl[i].ev, tbl[i].ef,
                 $sformatf("vec%0d", i));
        end

        // load with gaps; fetch in the start cycle is still served
        tick(1, 0, 32'h8, 1, 0, 0, 0, 32'h00221818, 1, 0, "ld start");
        chk("ld busy", 32'(busy), 32'h1);
        wl = '{32'hA, 32'h0, 32'hB, 32'h0, 32'hC};
        vl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ll = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        sl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 32'h0, sl[i], vl[i], ll[i], wl[i],
                 32'h00221818, 0, 0, $sformatf("ld%0d", i));
            chk($sformatf("ld%0d done", i), 32'(load_done), 32'((i == 4)));
        end
        chk("ld end busy", 32'(busy), 32'h0);
        tick(1, 0, 32'h0, 0, 0, 0, 0, 32'hA, 1, 0, "rd0");
        chk("done once", 32'(load_done), 32'h0);
        tick(1, 0, 32'h4, 0, 0, 0, 0, 32'hB, 1, 0, "rd1");
        tick(1, 0, 32'h8, 0, 0, 0, 0, 32'hC, 1, 0, "rd2");
        tick(1, 0, 32'hC, 0, 0, 0, 0, 32'h33333333, 1, 0, "rd3");

        // reset asserted mid-cycle clears outputs at once
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 0, 32'h4, 0, 0, 0, 0, 32'hB, 1, 0, "postrst");

        // DEPTH=4: loader exits after the last slot
        tick4(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick4(0, 0, 0, 1, 32'h100 + 32'(i));
            chk("ovf done", 32'(done4), 32'((i == 3)));
            chk("ovf busy", 32'(busy4), 32'((i != 3)));
        end
        tick4(0, 0, 0, 1, 32'hDEAD);
        chk("extra done", 32'(done4), 32'h0);
        chk("extra busy", 32'(busy4), 32'h0);
        tick4(1, 32'h0, 0, 0, 0);
        chk("d4 rd0", i4, 32'h100);
        chk("d4 rd0 v", 32'(v4), 32'h1);
        tick4(1, 32'hC, 0, 0, 0);
        chk("d4 rd3", i4, 32'h103);
        chk("d4 rd3 f", 32'(f4), 32'h0);
        tick4(1, 32'h10, 0, 0, 0);
        chk("d4 oob i", i4, 32'h0);
        chk("d4 oob f", 32'(f4), 32'h1);
        tick4(1, 32'h40, 0, 0, 0);
        chk("d4 alias f", 32'(f4), 32'h1);

        // DEPTH=4: reset aborts a partial load
        tick4(0, 0, 1, 0, 0);
        tick4(0, 0, 0, 1, 32'h200);
        tick4(0, 0, 0, 1, 32'h201);
        @(negedge clk);
        #2;
        rst4_n = 1'b0;
        lv4    = 1'b0;
        #1;
        chk("abort busy", 32'(busy4), 32'h0);
        chk("abort done", 32'(done4), 32'h0);
        chk("abort ready", 32'(rdy4), 32'h0);
        @(negedge clk);
        rst4_n = 1'b1;
        tick4(0, 0, 0, 0, 0);
        chk("abort no done", 32'(done4), 32'h0);
        chk("abort run", 32'(busy4), 32'h0);
        tick4(1, 32'h0, 0, 0, 0);
        chk("abort w0", i4, 32'h200);
        tick4(1, 32'h4, 0, 0, 0);
        chk("abort w1", i4, 32'h201);
        tick4(1, 32'h8, 0, 0, 0);
        chk("abort w2", i4, 32'h102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
